score_overlay_vga: RTL and testbench

SCORE_OVERLAY_VGA -- requirements
Module: score_overlay_vga

---
 rtl/score_overlay_vga.sv | 212 +++++++++++++++++++++
 tb/tb_score_overlay_vga.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/score_overlay_vga.sv
// rtl/score_overlay_vga.sv - BCD score counter with a 640x480 VGA digit overlay
// Timing, shadow and two-stage pixel pipeline all advance on pix_en.
module score_overlay_vga #(
    parameter int DIGITS  = 4,
    parameter int X0      = 590,
    parameter int Y0      = 40,
    parameter int SCALE   = 4,
    parameter int WRAP    = 1,
    parameter int LZB     = 1,
    parameter int PIX_DIV = 4
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  clr,
    input  logic                  stop,
    output logic                  hsync,
    output logic                  vsync,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int CW = 6 * SCALE;
    localparam int CH = 7 * SCALE;

    logic [DW-1:0]       div;
    logic                pix_en;
    logic [9:0]          hcount;
    logic [9:0]          vcount;
    logic [4*DIGITS-1:0] bcd_inc;
    logic                all_nines;
    logic [4*DIGITS-1:0] shadow;

    logic                vis_c, hit_c;
    logic [2:0]          idx_c, col_c, row_c;
    logic                s1_vis, s1_hit, s1_hs, s1_vs;
    logic [2:0]          s1_idx, s1_col, s1_row;
    logic [3:0]          digit;
    logic                blank;
    logic [4:0]          row_bits;
    logic [4:0]          shifted;
    logic                pix_on;

    // Rows are packed MSB-first; bit 4 of each row is the leftmost column.
    function automatic logic [4:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
        logic [34:0] g;
        case (d)
            4'd0: g = 35'b01110_10001_10011_10101_11001_10001_01110;
            4'd1: g = 35'b00100_01100_00100_00100_00100_00100_01110;
            4'd2: g = 35'b01110_10001_00001_00010_00100_01000_11111;
            4'd3: g = 35'b11111_00010_00100_00010_00001_10001_01110;
            4'd4: g = 35'b00010_00110_01010_10010_11111_00010_00010;
            4'd5: g = 35'b11111_10000_11110_00001_00001_10001_01110;
            4'd6: g = 35'b00110_01000_10000_11110_10001_10001_01110;
            4'd7: g = 35'b11111_00001_00010_00100_01000_01000_01000;
            4'd8: g = 35'b01110_10001_10001_01110_10001_10001_01110;
            4'd9: g = 35'b01110_10001_10001_01111_00001_00010_01100;
            default: g = '0;
        endcase
        if (r > 3'd6) glyph_row = 5'd0;
        else          glyph_row = 5'(g >> (5 * (6 - int'(r))));
    endfunction

    assign pix_en = (div == DW'(PIX_DIV - 1));

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)      div <= '0;
        else if (pix_en) div <= '0;
        else             div <= div + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (hcount == 10'd799) begin
                hcount <= '0;
                vcount <= (vcount == 10'd520) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end
    end

    // Decimal ripple increment; a carry out of the top digit means all nines.
    always_comb begin
        logic carry;
        bcd_inc = bcd;
        carry   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (bcd[4*k +: 4] == 4'd9) begin
                    bcd_inc[4*k +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*k +: 4] = bcd[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (!stop && inc) begin
            if (all_nines) overflow <= 1'b1;
            if (!(all_nines && WRAP == 0)) bcd <= bcd_inc;
        end
    end

    // Frame-start snapshot keeps a whole frame on one score value.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)
            shadow <= '0;
        else if (pix_en && hcount == 10'd0 && vcount == 10'd0)
            shadow <= bcd;
    end

    always_comb begin
        vis_c = (hcount >= 10'd144) && (hcount <= 10'd783) &&
                (vcount >= 10'd35)  && (vcount <= 10'd514);
        hit_c = 1'b0;
        idx_c = '0;
        col_c = '0;
        row_c = '0;
        if (int'(vcount) >= Y0 && int'(vcount) < Y0 + CH) begin
            row_c = 3'((int'(vcount) - Y0) / SCALE);
            for (int i = 0; i < DIGITS; i++) begin
                if (int'(hcount) >= X0 + CW * i && int'(hcount) < X0 + CW * (i + 1)) begin
                    hit_c = 1'b1;
                    idx_c = 3'(i);
                    col_c = 3'((int'(hcount) - X0 - CW * i) / SCALE);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            s1_vis <= 1'b0;
            s1_hit <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_idx <= '0;
            s1_col <= '0;
            s1_row <= '0;
        end else if (pix_en) begin
            s1_vis <= vis_c;
            s1_hit <= hit_c;
            s1_hs  <= (hcount < 10'd96);
            s1_vs  <= (vcount < 10'd2);
            s1_idx <= idx_c;
            s1_col <= col_c;
            s1_row <= row_c;
        end
    end

    // Position 0 is the most significant digit; the last position is never blanked.
    always_comb begin
        logic zero_run;
        digit    = '0;
        blank    = 1'b0;
        zero_run = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            zero_run = zero_run && (shadow[4*(DIGITS-1-i) +: 4] == 4'd0);
            if (s1_idx == 3'(i)) begin
                digit = shadow[4*(DIGITS-1-i) +: 4];
                blank = (LZB != 0) && zero_run && (i != DIGITS - 1);
            end
        end
        row_bits = glyph_row(digit, s1_row);
        shifted  = row_bits << s1_col;
        pix_on   = s1_hit && !blank && shifted[4];
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (pix_en) begin
            hsync <= s1_hs;
            vsync <= s1_vs;
            if (!s1_vis) begin
                red   <= 4'd0;
                green <= 4'd0;
                blue  <= 4'd0;
            end else if (pix_on) begin
                red   <= 4'd0;
                green <= 4'd0;
                blue  <= 4'd15;
            end else begin
                red   <= 4'd15;
                green <= 4'd15;
                blue  <= 4'd15;
            end
        end
    end

endmodule

// File: tb/tb_score_overlay_vga.sv
// tb/tb_score_overlay_vga.sv - self-checking bench for score_overlay_vga
module tb_score_overlay_vga;

    localparam int PD = 2;

    logic        sys_clk = 1'b0;
    logic        reset, inc, clr, stop;
    logic        hs_a, vs_a, ov_a, hs_b, vs_b, ov_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic [15:0] bcd_a, bcd_b;

    score_overlay_vga #(.DIGITS(4), .X0(150), .Y0(35), .SCALE(2), .WRAP(1), .LZB(1), .PIX_DIV(PD)) dut_a (
        .sys_clk(sys_clk), .reset(reset), .inc(inc), .clr(clr), .stop(stop),
        .hsync(hs_a), .vsync(vs_a), .red(r_a), .green(g_a), .blue(b_a),
        .bcd(bcd_a), .overflow(ov_a));

    score_overlay_vga #(.DIGITS(4), .X0(300), .Y0(35), .SCALE(1), .WRAP(0), .LZB(0), .PIX_DIV(PD)) dut_b (
        .sys_clk(sys_clk), .reset(reset), .inc(inc), .clr(clr), .stop(stop),
        .hsync(hs_b), .vsync(vs_b), .red(r_b), .green(g_b), .blue(b_b),
        .bcd(bcd_b), .overflow(ov_b));

    always #5 sys_clk = ~sys_clk;

    int n;
    always @(posedge sys_clk or negedge reset) begin
        if (!reset) n <= 0;
        else        n <= n + 1;
    end

    typedef struct {
        logic        c;
        logic        s;
        logic        i;
        int          n;
        logic [15:0] ea;
        logic        oa;
        logic [15:0] eb;
        logic        ob;
    } vec_t;

    int     tests  = 0;
    int     failed = 0;
    bit     done   = 0;
    string  glyph [10][7];
    vec_t   tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        logic [15:0] r;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((s / (10 ** k)) % 10);
        return r;
    endfunction

    // Expected {hsync, vsync, rgb} for display pixel index p of the first frame.
    function automatic logic [13:0] pix_model(input int p, input int x0, input int y0,
                                              input int sc, input int lzb, input int s);
        int h, v, i, col, row, place, dig;
        logic hs, vs;
        logic [11:0] rgb;
        if (p < 0) return 14'd0;
        h = p % 800;
        v = (p / 800) % 521;
        hs = (h < 96);
        vs = (v < 2);
        rgb = 12'h000;
        if (h >= 144 && h <= 783 && v >= 35 && v <= 514) begin
            rgb = 12'hFFF;
            if (v >= y0 && v < y0 + 7 * sc && h >= x0 && h < x0 + 24 * sc) begin
                i     = (h - x0) / (6 * sc);
                col   = ((h - x0) % (6 * sc)) / sc;
                row   = (v - y0) / sc;
                place = 10 ** (3 - i);
                dig   = (s / place) % 10;
                if (!(lzb != 0 && i < 3 && s < place) && col < 5 && glyph[dig][row][col] == "#")
                    rgb = 12'h00F;
            end
        end
        return {hs, vs, rgb};
    endfunction

    // Displayed score is the value latched at the first pixel tick (1).
    task automatic pixel_checker();
        int cur, bad_a, bad_b, p, line;
        cur = 0; bad_a = 0; bad_b = 0;
        for (int it = 0; it < 200000 && cur < 44; it++) begin
            @(posedge sys_clk); #1;
            p = (n >= 2 * PD) ? n / PD - 2 : -1;
            line = (p < 0) ? 0 : p / 800;
            if (line != cur) begin
                check($sformatf("line%0d_a", cur), bad_a, 0);
                check($sformatf("line%0d_b", cur), bad_b, 0);
                cur = line; bad_a = 0; bad_b = 0;
            end
            if ({hs_a, vs_a, r_a, g_a, b_a} !== pix_model(p, 150, 35, 2, 1, 1)) bad_a++;
            if ({hs_b, vs_b, r_b, g_b, b_b} !== pix_model(p, 300, 35, 1, 0, 1)) bad_b++;
        end
        check("checker_reached_line44", cur, 44);
        done = 1;
    endtask

    initial begin
        int sa, sb, bad;
        logic oa, ob;

        reset = 1'b0; inc = 1'b0; clr = 1'b0; stop = 1'b0;
        glyph = '{
            '{".###.", "#...#", "#..##", "#.#.#", "##..#", "#...#", ".###."},
            '{"..#..", ".##..", "..#..", "..#..", "..#..", "..#..", ".###."},
            '{".###.", "#...#", "....#", "...#.", "..#..", ".#...", "#####"},
            '{"#####", "...#.", "..#..", "...#.", "....#", "#...#", ".###."},
            '{"...#.", "..##.", ".#.#.", "#..#.", "#####", "...#.", "...#."},
            '{"#####", "#....", "####.", "....#", "....#", "#...#", ".###."},
            '{"..##.", ".#...", "#....", "####.", "#...#", "#...#", ".###."},
            '{"#####", "....#", "...#.", "..#..", ".#...", ".#...", ".#..."},
            '{".###.", "#...#", "#...#", ".###.", "#...#", "#...#", ".###."},
            '{".###.", "#...#", "#...#", ".####", "....#", "...#.", ".##.."}
        };
        tbl = '{
            '{1'b1, 1'b0, 1'b0, 1,    16'h0000, 1'b0, 16'h0000, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1234, 16'h1234, 1'b0, 16'h1234, 1'b0},
            '{1'b0, 1'b1, 1'b1, 10,   16'h1234, 1'b0, 16'h1234, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1,    16'h0000, 1'b0, 16'h0000, 1'b0},
            '{1'b0, 1'b0, 1'b1, 9999, 16'h9999, 1'b0, 16'h9999, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1,    16'h0000, 1'b1, 16'h9999, 1'b1},
            '{1'b0, 1'b0, 1'b1, 1,    16'h0001, 1'b1, 16'h9999, 1'b1},
            '{1'b0, 1'b1, 1'b1, 3,    16'h0001, 1'b1, 16'h9999, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1,    16'h0000, 1'b0, 16'h0000, 1'b0},
            '{1'b0, 1'b0, 1'b1, 7,    16'h0007, 1'b0, 16'h0007, 1'b0}
        };

        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_bcd_a", bcd_a, 0);
        check("rst_ovf_a", ov_a, 0);
        check("rst_sync_a", {hs_a, vs_a}, 0);
        check("rst_rgb_a", {r_a, g_a, b_a}, 0);
        check("rst_bcd_b", bcd_b, 0);
        check("rst_out_b", {ov_b, hs_b, vs_b, r_b, g_b, b_b}, 0);

        @(negedge sys_clk);
        reset = 1'b1;
        inc   = 1'b1;
        fork
            pixel_checker();
        join_none
        @(posedge sys_clk); #1;
        inc = 1'b0;
        check("first_inc_a", bcd_a, 16'h0001);

        foreach (tbl[k]) begin
            clr = tbl[k].c; stop = tbl[k].s; inc = tbl[k].i;
            repeat (tbl[k].n) @(posedge sys_clk);
            #1;
            clr = 1'b0; stop = 1'b0; inc = 1'b0;
            check($sformatf("vec%0d_a", k), {ov_a, bcd_a}, {tbl[k].oa, tbl[k].ea});
            check($sformatf("vec%0d_b", k), {ov_b, bcd_b}, {tbl[k].ob, tbl[k].eb});
        end

        sa = 7; sb = 7; oa = 1'b0; ob = 1'b0;
        for (int blk = 0; blk < 1000 && !done; blk++) begin
            bad = 0;
            repeat (200) begin
                clr  = ($urandom_range(63) == 0);
                stop = ($urandom_range(7) == 0);
                inc  = 1'($urandom_range(1));
                @(posedge sys_clk); #1;
                if (clr) begin
                    sa = 0; sb = 0; oa = 1'b0; ob = 1'b0;
                end else if (!stop && inc) begin
                    if (sa == 9999) begin sa = 0; oa = 1'b1; end
                    else sa = sa + 1;
                    if (sb == 9999) ob = 1'b1;
                    else sb = sb + 1;
                end
                if (bcd_a !== to_bcd(sa) || ov_a !== oa || bcd_b !== to_bcd(sb) || ov_b !== ob)
                    bad++;
            end
            check($sformatf("rand_blk%0d", blk), bad, 0);
        end
        clr = 1'b0; stop = 1'b0;

        inc = 1'b1;
        for (int k = 0; k < 5000 && (n / PD - 2) < 44 * 800 + 400; k++) begin
            @(posedge sys_clk); #1;
        end
        inc = 1'b0;
        check("pre_reset_pixel_a", {hs_a, vs_a, r_a, g_a, b_a}, pix_model(n / PD - 2, 150, 35, 2, 1, 1));
        #2 reset = 1'b0;
        #1;
        check("async_rst_bcd_a", bcd_a, 0);
        check("async_rst_rgb_a", {r_a, g_a, b_a}, 0);
        check("async_rst_sync_ovf_a", {hs_a, vs_a, ov_a}, 0);
        check("async_rst_all_b", {bcd_b, ov_b, hs_b, vs_b, r_b, g_b, b_b}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
